// File: rtl/qbuff_ctrl_pkg.sv
// Shared types and constants for the qualified-buffer capture sequencer.
//   state_t : sequencer state encoding
//   SRC_INT : cfg_src value selecting an immediate start for each shot
//   SRC_EXT : cfg_src value selecting an external-trigger start for each shot
package qbuff_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WIN,
        RD,
        GAP,
        FIN
    } state_t;

    localparam logic SRC_INT = 1'b0;
    localparam logic SRC_EXT = 1'b1;

endpackage

// File: rtl/qbuff_ctrl_dcnt.sv
// Loadable down-counter, shared by the capture window and the inter-shot gap.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over en)
//   en        : decrement by one; holds at zero
//   load_val  : value loaded on load
//   is_zero   : count is zero
//   is_one    : count is one
module qbuff_ctrl_dcnt #(
    parameter int unsigned B_CNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [B_CNT-1:0] load_val,
    output logic             is_zero,
    output logic             is_one
);

    localparam logic [B_CNT-1:0] CNT_ONE = B_CNT'(1);

    logic [B_CNT-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    assign is_zero = (count_q == '0);
    assign is_one  = (count_q == CNT_ONE);

endmodule

// File: rtl/qbuff_seq_ctrl.sv
// Multi-shot capture sequencer for the qualified buffer. Runs N capture
// windows, each optionally followed by a readout, separated by a programmable gap.
//   aclk, areset           : clock (buffer s_axis domain), async active-high reset
//   cfg_go, cfg_abort      : single-cycle start / terminate pulses
//   cfg_src                : per-shot start source (SRC_INT / SRC_EXT)
//   cfg_nshots/win/gap     : shot count, window length, post-shot holdoff
//   cfg_rd_auto            : request a readout after each successful shot
//   trig_in                : external trigger level (rising edge used)
//   wmem_full              : buffer write memory full
//   rd_tvalid/tready/tlast : readout stream monitor
//   qb_start, qb_rmem_start: buffer start level, one-cycle readout request
//   busy, done             : sequence active, one-cycle completion pulse
//   shot_cnt, timeout_err  : completed shots, sticky window-timeout flag
module qbuff_seq_ctrl
    import qbuff_ctrl_pkg::*;
#(
    parameter int unsigned B_CNT  = 16,
    parameter int unsigned B_SHOT = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_go,
    input  logic              cfg_abort,
    input  logic              cfg_src,
    input  logic [B_SHOT-1:0] cfg_nshots,
    input  logic [B_CNT-1:0]  cfg_win,
    input  logic [B_CNT-1:0]  cfg_gap,
    input  logic              cfg_rd_auto,
    input  logic              trig_in,
    input  logic              wmem_full,
    input  logic              rd_tvalid,
    input  logic              rd_tready,
    input  logic              rd_tlast,
    output logic              qb_start,
    output logic              qb_rmem_start,
    output logic              busy,
    output logic              done,
    output logic [B_SHOT-1:0] shot_cnt,
    output logic              timeout_err
);

    localparam logic [B_SHOT-1:0] SHOT_ONE = B_SHOT'(1);
    localparam logic [B_CNT-1:0]  CNT_ONE  = B_CNT'(1);

    state_t            state_q, state_d;
    logic              trig_d, trig_edge;
    logic              src_q, rd_auto_q;
    logic [B_SHOT-1:0] nshots_q;
    logic [B_CNT-1:0]  win_q, gap_q;
    logic              rd_first_q, rd_first_d;

    logic              cnt_load, cnt_en, cnt_zero, cnt_one;
    logic [B_CNT-1:0]  cnt_val;

    logic              go_accept, rd_hs, win_end, gap_end;
    logic [B_SHOT-1:0] shot_next;

    logic              qb_start_d, qb_rmem_start_d, busy_d, done_d, timeout_err_d;
    logic [B_SHOT-1:0] shot_cnt_d;

    assign trig_edge = trig_in & ~trig_d;
    assign go_accept = cfg_go & ~cfg_abort & (state_q == IDLE);
    assign rd_hs     = rd_tvalid & rd_tready & rd_tlast;
    // Zero is included so a degenerate count can never stall the sequence.
    assign win_end   = cnt_one | cnt_zero;
    assign gap_end   = cnt_one | cnt_zero;
    assign shot_next = (shot_cnt == {B_SHOT{1'b1}}) ? shot_cnt : shot_cnt + SHOT_ONE;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cfg_go) state_d = ARM;
                ARM:  if ((src_q == SRC_INT) || trig_edge) state_d = WIN;
                WIN: begin
                    if (wmem_full) begin
                        state_d = rd_auto_q ? RD : GAP;
                    end else if (win_end) begin
                        state_d = GAP;
                    end
                end
                RD:   if (rd_hs) state_d = GAP;
                GAP:  if (gap_end) state_d = (shot_next == nshots_q) ? FIN : ARM;
                FIN:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter reload on entry to WIN or GAP, count down while in either
    always_comb begin
        cnt_load = ((state_d == WIN) && (state_q != WIN)) ||
                   ((state_d == GAP) && (state_q != GAP));
        cnt_val  = (state_d == WIN) ? win_q : gap_q;
        cnt_en   = (state_q == WIN) || (state_q == GAP);
    end

    qbuff_ctrl_dcnt #(
        .B_CNT (B_CNT)
    ) u_dcnt (
        .clk      (aclk),
        .rst      (areset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    // Output logic: outputs follow the state one cycle later, except that
    // abort drops them at the same edge it takes effect.
    always_comb begin
        qb_start_d      = ~cfg_abort & (state_q == WIN);
        qb_rmem_start_d = ~cfg_abort & (state_q == RD) & rd_first_q;
        busy_d          = ~cfg_abort & (state_q != IDLE);
        done_d          = ~cfg_abort & (state_q == FIN);
        rd_first_d      = (state_d == RD) && (state_q != RD);

        shot_cnt_d = shot_cnt;
        if (go_accept) begin
            shot_cnt_d = '0;
        end else if (!cfg_abort && (state_q == GAP) && gap_end) begin
            shot_cnt_d = shot_next;
        end

        timeout_err_d = timeout_err;
        if (go_accept) begin
            timeout_err_d = 1'b0;
        end else if (!cfg_abort && (state_q == WIN) && !wmem_full && win_end) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            qb_start      <= 1'b0;
            qb_rmem_start <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            shot_cnt      <= '0;
            timeout_err   <= 1'b0;
            rd_first_q    <= 1'b0;
            trig_d        <= 1'b0;
        end else begin
            qb_start      <= qb_start_d;
            qb_rmem_start <= qb_rmem_start_d;
            busy          <= busy_d;
            done          <= done_d;
            shot_cnt      <= shot_cnt_d;
            timeout_err   <= timeout_err_d;
            rd_first_q    <= rd_first_d;
            trig_d        <= trig_in;
        end
    end

    // Configuration snapshot taken when a go is accepted; zero counts become one
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            src_q     <= SRC_INT;
            rd_auto_q <= 1'b0;
            nshots_q  <= SHOT_ONE;
            win_q     <= CNT_ONE;
            gap_q     <= '0;
        end else if (go_accept) begin
            src_q     <= cfg_src;
            rd_auto_q <= cfg_rd_auto;
            nshots_q  <= (cfg_nshots == '0) ? SHOT_ONE : cfg_nshots;
            win_q     <= (cfg_win == '0) ? CNT_ONE : cfg_win;
            gap_q     <= cfg_gap;
        end
    end

endmodule

// File: tb/tb_qbuff_seq_ctrl.sv
// Self-checking bench for qbuff_seq_ctrl: directed scenarios plus a randomized
// run, all compared every cycle against a phase/elapsed-time reference model.
module tb_qbuff_seq_ctrl;

    localparam int B_CNT  = 16;
    localparam int B_SHOT = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cfg_go, cfg_abort, cfg_src, cfg_rd_auto, trig_in;
    logic [B_SHOT-1:0] cfg_nshots;
    logic [B_CNT-1:0]  cfg_win, cfg_gap;
    logic              wmem_full, rd_tvalid, rd_tready, rd_tlast;
    logic              qb_start, qb_rmem_start, busy, done, timeout_err;
    logic [B_SHOT-1:0] shot_cnt;

    always #5 aclk = ~aclk;

    qbuff_seq_ctrl #(
        .B_CNT  (B_CNT),
        .B_SHOT (B_SHOT)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_go        (cfg_go),
        .cfg_abort     (cfg_abort),
        .cfg_src       (cfg_src),
        .cfg_nshots    (cfg_nshots),
        .cfg_win       (cfg_win),
        .cfg_gap       (cfg_gap),
        .cfg_rd_auto   (cfg_rd_auto),
        .trig_in       (trig_in),
        .wmem_full     (wmem_full),
        .rd_tvalid     (rd_tvalid),
        .rd_tready     (rd_tready),
        .rd_tlast      (rd_tlast),
        .qb_start      (qb_start),
        .qb_rmem_start (qb_rmem_start),
        .busy          (busy),
        .done          (done),
        .shot_cnt      (shot_cnt),
        .timeout_err   (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_ARM = 1, P_WIN = 2, P_RD = 3, P_GAP = 4, P_FIN = 5;
    int m_phase, m_elapsed, m_nshots, m_win, m_gap, e_shot;
    bit m_src, m_rd_auto, m_trig_prev;
    bit e_qb, e_rm, e_busy, e_done, e_tmo;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_phase = P_IDLE; m_elapsed = 0; m_trig_prev = 0;
            m_src = 0; m_rd_auto = 0; m_nshots = 1; m_win = 1; m_gap = 0;
            e_qb = 0; e_rm = 0; e_busy = 0; e_done = 0; e_shot = 0; e_tmo = 0;
        end else begin
            bit edge_seen, ab;
            int nxt;
            edge_seen   = trig_in && !m_trig_prev;
            m_trig_prev = trig_in;
            ab          = cfg_abort;
            // outputs describe the phase occupied during the cycle just ended
            e_qb   = !ab && (m_phase == P_WIN);
            e_rm   = !ab && (m_phase == P_RD) && (m_elapsed == 0);
            e_busy = !ab && (m_phase != P_IDLE);
            e_done = !ab && (m_phase == P_FIN);
            nxt = m_phase;
            if (ab) begin
                nxt = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE: if (cfg_go) begin
                        m_src     = cfg_src;
                        m_rd_auto = cfg_rd_auto;
                        m_nshots  = (cfg_nshots == 0) ? 1 : int'(cfg_nshots);
                        m_win     = (cfg_win == 0) ? 1 : int'(cfg_win);
                        m_gap     = int'(cfg_gap);
                        e_shot = 0; e_tmo = 0;
                        nxt = P_ARM;
                    end
                    P_ARM: if (!m_src || edge_seen) nxt = P_WIN;
                    P_WIN: begin
                        if (wmem_full) nxt = m_rd_auto ? P_RD : P_GAP;
                        else if (m_elapsed + 1 >= m_win) begin
                            e_tmo = 1;
                            nxt = P_GAP;
                        end
                    end
                    P_RD: if (rd_tvalid && rd_tready && rd_tlast) nxt = P_GAP;
                    P_GAP: if (m_elapsed + 1 >= ((m_gap == 0) ? 1 : m_gap)) begin
                        if (e_shot < 255) e_shot++;
                        nxt = (e_shot == m_nshots) ? P_FIN : P_ARM;
                    end
                    default: nxt = P_IDLE;
                endcase
            end
            m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
            m_phase   = nxt;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge aclk) begin
        if (!areset) begin
            chk("qb_start", int'(qb_start), int'(e_qb));
            chk("qb_rmem_start", int'(qb_rmem_start), int'(e_rm));
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
            chk("shot_cnt", int'(shot_cnt), e_shot);
            chk("timeout_err", int'(timeout_err), int'(e_tmo));
        end
    end

    // ---------------- activity monitor ----------------
    int bursts = 0, qb_hi = 0, rm_cnt = 0, done_cnt = 0, cur_len = 0;
    int blen[$];
    bit prev_qb = 0;

    always @(negedge aclk) begin
        if (qb_start) begin
            qb_hi++;
            cur_len++;
            if (!prev_qb) bursts++;
        end else if (prev_qb) begin
            blen.push_back(cur_len);
            cur_len = 0;
        end
        if (qb_rmem_start) rm_cnt++;
        if (done) done_cnt++;
        prev_qb = qb_start;
    end

    // ---------------- buffer responder ----------------
    int wm_mode = 0, wm_at = 3, rd_mode = 0, rd_delay = 10;
    int qb_run = 0, rd_cnt = 0;

    always @(negedge aclk) begin
        bit hs;
        qb_run = qb_start ? qb_run + 1 : 0;
        case (wm_mode)
            0:       wmem_full = 1'b0;
            1:       wmem_full = (qb_run == wm_at);
            default: wmem_full = ($urandom_range(0, 5) == 0);
        endcase
        if (rd_mode == 0) begin
            if (qb_rmem_start) rd_cnt = 1;
            else if (rd_cnt > 0) rd_cnt++;
            hs = (rd_cnt == rd_delay);
            if (hs) rd_cnt = 0;
            rd_tvalid = hs; rd_tready = hs; rd_tlast = hs;
        end else begin
            rd_tvalid = ($urandom_range(0, 1) == 1);
            rd_tready = ($urandom_range(0, 1) == 1);
            rd_tlast  = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input bit src, input int nsh, input int win, input int gap,
                           input bit rda);
        cfg_src = src; cfg_nshots = B_SHOT'(nsh); cfg_win = B_CNT'(win);
        cfg_gap = B_CNT'(gap); cfg_rd_auto = rda;
    endtask

    task automatic pulse_go();
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        chk(name, done_cnt - d0, 1);
    endtask

    int d0, b0, q0, r0, l0;

    initial begin
        areset = 1'b1;
        cfg_go = 0; cfg_abort = 0; trig_in = 0;
        set_cfg(0, 1, 1, 0, 0);
        ticks(3);
        chk("reset qb_start", int'(qb_start), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset shot_cnt", int'(shot_cnt), 0);
        chk("reset timeout_err", int'(timeout_err), 0);
        areset = 1'b0;
        ticks(2);

        // 1: single shot, window expires
        d0 = done_cnt; b0 = bursts; q0 = qb_hi;
        wm_mode = 0; rd_mode = 0;
        set_cfg(0, 1, 8, 0, 0);
        tick();
        pulse_go();
        chk("t1 busy after edge0", int'(busy), 0);
        tick();
        chk("t1 busy after edge1", int'(busy), 1);
        chk("t1 qb_start after edge1", int'(qb_start), 0);
        tick();
        chk("t1 qb_start after edge2", int'(qb_start), 1);
        wait_done("t1 done", d0, 100);
        ticks(2);
        chk("t1 qb_start cycles", qb_hi - q0, 8);
        chk("t1 bursts", bursts - b0, 1);
        chk("t1 timeout_err", int'(timeout_err), 1);
        chk("t1 shot_cnt", int'(shot_cnt), 1);

        // 2: three shots with early wmem_full and auto readout
        d0 = done_cnt; b0 = bursts; r0 = rm_cnt; l0 = blen.size();
        wm_mode = 1; wm_at = 3; rd_mode = 0; rd_delay = 10;
        set_cfg(0, 3, 100, 5, 1);
        pulse_go();
        wait_done("t2 done", d0, 1000);
        ticks(2);
        chk("t2 bursts", bursts - b0, 3);
        for (int i = l0; i < blen.size(); i++) chk("t2 burst length", blen[i], 4);
        chk("t2 rmem pulses", rm_cnt - r0, 3);
        chk("t2 shot_cnt", int'(shot_cnt), 3);
        chk("t2 timeout_err", int'(timeout_err), 0);

        // 3: external trigger; IDLE/GAP edges and held-high level ignored
        wm_mode = 0;
        d0 = done_cnt; b0 = bursts;
        trig_in = 1; tick(); trig_in = 0; ticks(3);
        set_cfg(1, 2, 3, 20, 0);
        pulse_go();
        ticks(4);
        trig_in = 1;
        ticks(8);
        trig_in = 0; ticks(2); trig_in = 1;
        ticks(40);
        chk("t3 bursts while held", bursts - b0, 1);
        chk("t3 busy armed", int'(busy), 1);
        chk("t3 shot_cnt mid", int'(shot_cnt), 1);
        trig_in = 0; tick(); trig_in = 1;
        tick();
        chk("t3 qb_start edge+1", int'(qb_start), 0);
        tick();
        chk("t3 qb_start edge+2", int'(qb_start), 1);
        wait_done("t3 done", d0, 100);
        chk("t3 bursts", bursts - b0, 2);
        chk("t3 shot_cnt", int'(shot_cnt), 2);
        trig_in = 0;
        ticks(3);

        // 4: abort during shot 2 window; go while busy ignored
        d0 = done_cnt; b0 = bursts;
        set_cfg(0, 4, 20, 3, 0);
        pulse_go();
        ticks(5);
        pulse_go();
        for (int i = 0; i < 200 && bursts - b0 < 2; i++) tick();
        chk("t4 reached shot 2", bursts - b0, 2);
        ticks(2);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t4 qb_start after abort", int'(qb_start), 0);
        chk("t4 busy after abort", int'(busy), 0);
        ticks(10);
        chk("t4 shot_cnt", int'(shot_cnt), 1);
        chk("t4 timeout_err kept", int'(timeout_err), 1);
        chk("t4 no done", done_cnt - d0, 0);
        cfg_go = 1'b1; cfg_abort = 1'b1; tick();
        cfg_go = 1'b0; cfg_abort = 1'b0; ticks(2);
        chk("t4 go+abort dropped", int'(busy), 0);

        // 5: zero config means one shot, one-cycle window and gap
        d0 = done_cnt; b0 = bursts; l0 = blen.size();
        set_cfg(0, 0, 0, 0, 0);
        pulse_go();
        wait_done("t5 done", d0, 50);
        ticks(2);
        chk("t5 bursts", bursts - b0, 1);
        if (blen.size() > l0) chk("t5 burst length", blen[l0], 1);
        chk("t5 shot_cnt", int'(shot_cnt), 1);

        // 6: asynchronous reset mid-window
        b0 = bursts;
        set_cfg(0, 3, 10, 2, 0);
        pulse_go();
        for (int i = 0; i < 200 && bursts - b0 < 2; i++) tick();
        ticks(2);
        chk("t6 shot_cnt before reset", int'(shot_cnt), 1);
        @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("t6 qb_start in reset", int'(qb_start), 0);
        chk("t6 busy in reset", int'(busy), 0);
        chk("t6 shot_cnt in reset", int'(shot_cnt), 0);
        ticks(3);
        areset = 1'b0;
        ticks(4);
        chk("t6 idle busy", int'(busy), 0);
        chk("t6 idle qb_start", int'(qb_start), 0);

        // 7: randomized traffic, compared cycle by cycle
        d0 = done_cnt;
        wm_mode = 2; rd_mode = 1;
        for (int i = 0; i < 6000; i++) begin
            set_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 8),
                    $urandom_range(0, 5), $urandom_range(0, 1) == 1);
            cfg_go    = ($urandom_range(0, 14) == 0);
            cfg_abort = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) trig_in = ~trig_in;
            tick();
        end
        cfg_go = 0; cfg_abort = 0;
        chk("t7 sequences completed", int'(done_cnt - d0 > 0), 1);
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
